seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-sequence detector, the parametrised successor of the fixed 6-bit detectors.
- Pattern, length (1..MAX_LEN) and overlap mode are loaded through a config strobe.
- Serial input is qualified by a valid.
- Produces a registered one-cycle match pulse and a saturating match counter.
- Sits between the serial front end and status/interrupt logic.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits (>=2).
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_load  in  1  single-cycle strobe; samples cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- cfg_err  out  1  one-cycle pulse; the load was rejected because of an illegal length.
- a_valid  in  1  a is sampled only when high.
- a  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- b  out  1  registered match pulse.
- match_cnt  out  CNT_W  count of matches since reset/load/clear; saturating.
- armed  out  1  high when configured (state RUN).

Behaviour:
- Reset (async, rstn low):
  - State goes to UNCFG.
  - Pattern, length, history and fill counter clear to 0; overlap clears to 0.
  - b=0, match_cnt=0, cfg_err=0, armed=0.
- States: UNCFG and RUN.
  - UNCFG -> RUN on an accepted cfg_load.
  - RUN -> RUN on any accepted cfg_load (reconfigure).
  - No path back to UNCFG except reset.
  - In UNCFG, b never asserts and a is ignored.
- Config acceptance:
  - Accepted when cfg_len is in 1..MAX_LEN.
  - An accepted load latches the fields, clears history, fill counter, b (next cycle) and match_cnt.
  - Rejected (cfg_len=0 or >MAX_LEN): cfg_err=1 the next cycle; state and stored config are unchanged.
- History shift:
  - Each cycle with a_valid=1 in RUN: hist <= {hist[MAX_LEN-2:0], a}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition (combinational, evaluated on the current valid bit):
  - Masked compare of ({hist[MAX_LEN-2:0],a} & mask) == (pattern & mask), where mask is the low len bits set.
  - Also requires fill+1 >= len.
  - Also requires a_valid=1 and state RUN.
- Output b:
  - b is registered: high exactly one cycle after the clock edge that sampled the final pattern bit.
  - Latency is 1 cycle; b is low in every other cycle.
- Overlap mode:
  - overlap=1: history and fill continue after a match, so a suffix may start the next match.
  - overlap=0: on a match, fill resets to 0 (history may keep shifting), so the next match requires len fresh valid bits.
- match_cnt:
  - Increments on each match.
  - Saturates at 2^CNT_W-1 and never wraps.
- Simultaneous events:
  - cfg_load together with a_valid: the load wins, the bit is discarded, and no match is evaluated that cycle.
  - cnt_clr together with a match: the clear wins, so match_cnt=0. b still pulses.
  - cfg_load together with cnt_clr: the load behaviour applies.
- a_valid gaps:
  - Invalid cycles are skipped entirely.
  - History and fill hold; a pattern spanning gaps still matches.
- len=1: every valid bit equal to pattern[0] produces a match.
  - In non-overlap mode it also matches every such bit, because one fresh bit suffices.
- Reset mid-stream: all state is lost immediately (async). After rstn rises, a new cfg_load is required.
- Timing: the comparator is a single masked MAX_LEN-bit equality, with no multi-cycle paths.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (UNCFG, RUN);
  - a LEN_W helper function;
  - a mask-generation function (len -> MAX_LEN-bit low mask).
- One sub-module, seq_det_cmp: a purely combinational masked comparator producing the hit signal from history, a, pattern and len.
- The top level holds the config registers, history, fill counter, FSM, b register and counter.

Test Plan:
- Overlap on: reset, load pattern=6'b101101, len=6, overlap=1; stream 1,0,1,1,0,1,1,0,1,1 with a_valid continuous.
  - b pulses the cycle after bit index 5 and after bit index 8.
  - match_cnt=2.
- Overlap off: same pattern and stream.
  - b pulses only after bit index 5.
  - match_cnt=1.
- Gaps: same as the first case with a_valid=0 for 3 cycles between bits 2 and 3.
  - Identical pulse count (2).
  - Each pulse is 1 cycle after its final valid bit.
- Illegal and mid-stream loads:
  - Load with cfg_len=0 -> cfg_err pulses, armed stays 0, and stream 101101 gives no b.
  - Then a valid load mid-stream with a_valid=1 on the same cycle -> that bit is discarded and match_cnt is 0.
- Saturation: CNT_W=2, len=1, pattern[0]=1, stream of 6 ones.
  - b high 6 cycles.
  - match_cnt stops at 3.
  - cnt_clr together with the 7th one -> match_cnt=0 while b is still 1.
- Full length: MAX_LEN=16, len=16, pattern 16'hA5C3.
  - The exact 16-bit stream -> one pulse.
  - The same stream with the first bit flipped -> no pulse.
  - Assert rstn=0 mid-stream -> b=0 and armed=0 immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the programmable sequence detector.
`default_nettype none

package seq_det_pkg;

  typedef enum logic [0:0] {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Widest mask the helper can build; MAX_LEN must not exceed this.
  localparam int MASK_W = 64;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low `len` bits set; the caller zero-extends its data to MASK_W bits.
  function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
    logic [MASK_W-1:0] m;
    if (len >= 32'(MASK_W)) m = '1;
    else                    m = (MASK_W'(1) << len) - MASK_W'(1);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_cmp.sv
// seq_det_cmp: combinational masked compare of {history, current bit} against the pattern.
`default_nettype none

module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] hist,
  input  logic               a,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] diff;

  always_comb begin
    diff = {hist, a} ^ pattern;
    hit  = ((MASK_W'(diff)) & len_mask(32'(len))) == '0;
  end

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial sequence detector with
// registered match pulse and saturating match counter.
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               a_valid,
  input  logic               a,
  input  logic               cnt_clr,
  output logic               b,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q,   state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-2:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic               b_q,       b_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic               len_ok;
  logic               accept;
  logic               shift_en;
  logic               fill_ok;
  logic               hit;
  logic               match;
  logic [MAX_LEN-2:0] hist_shift;

  // Only MAX_LEN-1 bits of history are ever compared; the current bit completes the window.
  generate
    if (MAX_LEN > 2) begin : g_shift_wide
      assign hist_shift = {hist_q[MAX_LEN-3:0], a};
    end else begin : g_shift_min
      assign hist_shift = a;
    end
  endgenerate

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_q),
    .a       (a),
    .pattern (pattern_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_comb begin
    len_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    accept   = cfg_load && len_ok;
    // Any load attempt owns the cycle, so the serial bit is dropped.
    shift_en = (state_q == RUN) && a_valid && !cfg_load;
    fill_ok  = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    match    = shift_en && hit && fill_ok;

    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    b_d       = 1'b0;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_load && !len_ok;

    if (accept) begin
      state_d   = RUN;
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      cnt_d     = '0;
    end else begin
      if (shift_en) begin
        hist_d = hist_shift;
        if (match && !overlap_q)     fill_d = '0;
        else if (fill_q != MAX_LEN_L) fill_d = fill_q + LEN_W'(1);
      end
      b_d = match;
      if (cnt_clr)                 cnt_d = '0;
      else if (match && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      b_q       <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign b         = b_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;
  assign armed     = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed stimulus with a pulse scoreboard for seq_detector_prog.
`default_nettype none

module tb_seq_detector_prog;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        cfg_err;
  logic        a_valid = 1'b0;
  logic        a = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        b;
  logic [1:0]  match_cnt;
  logic        armed;

  seq_detector_prog #(
    .MAX_LEN (16),
    .CNT_W   (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .a_valid     (a_valid),
    .a           (a),
    .cnt_clr     (cnt_clr),
    .b           (b),
    .match_cnt   (match_cnt),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;
  logic [1:0] exp_cnt = 2'd0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every b pulse must match the next queued expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_total = n_total + 1;
      $display("FAIL missed_b: no pulse, expected at cyc %0d", e.cyc);
    end
    if (b !== 1'b0) begin
      if (sb.size() == 0) begin
        n_total = n_total + 1;
        $display("FAIL unexpected_b: got b=%b at cyc %0d, expected 0", b, cyc);
      end else begin
        e = sb.pop_front();
        check("b_cycle", 32'(cyc), 32'(e.cyc));
        check("b_cnt", 32'(match_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic drive(input logic v, input logic bit_a, input logic clr,
                       input logic exp_hit, input logic [1:0] ecnt);
    exp_t e;
    @(negedge clk);
    cfg_load = 1'b0;
    a_valid  = v;
    a        = bit_a;
    cnt_clr  = clr;
    if (exp_hit) begin
      e.cyc = cyc + 1;
      e.cnt = ecnt;
      sb.push_back(e);
    end
  endtask

  // Stream n bits MSB first; hits marks the bits that complete a match.
  task automatic send(input logic [31:0] s, input int n, input logic [31:0] hits);
    for (int i = n - 1; i >= 0; i--) begin
      if (hits[i]) exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      drive(1'b1, s[i], 1'b0, hits[i], exp_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ov,
                      input logic v, input logic bit_a,
                      input logic exp_err, input logic exp_armed);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    a_valid     = v;
    a           = bit_a;
    cnt_clr     = 1'b0;
    @(negedge clk);
    cfg_load = 1'b0;
    a_valid  = 1'b0;
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    check("armed", 32'(armed), 32'(exp_armed));
    if (!exp_err) begin
      exp_cnt = 2'd0;
      check("cnt_after_load", 32'(match_cnt), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_b", 32'(b), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    exp_cnt = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Overlapping matches
    do_reset();
    load(16'b101101, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'b1011011011, 10, 32'b0000010010);
    idle(2);
    check("cnt_overlap", 32'(match_cnt), 32'd2);

    // Non-overlapping
    load(16'b101101, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'b1011011011, 10, 32'b0000010000);
    idle(2);
    check("cnt_no_overlap", 32'(match_cnt), 32'd1);

    // Valid gaps between bits 2 and 3
    load(16'b101101, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'b101, 3, 32'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    send(32'b1011011, 7, 32'b0010010);
    idle(2);
    check("cnt_gaps", 32'(match_cnt), 32'd2);

    // Illegal loads while unconfigured, then loads with a coincident valid bit
    do_reset();
    load(16'b101101, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("cfg_err_pulse_len", 32'(cfg_err), 32'd0);
    load(16'b101101, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'b101101, 6, 32'b0);
    idle(1);
    check("armed_after_illegal", 32'(armed), 32'd0);
    load(16'b101101, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send(32'b10110, 5, 32'b0);
    load(16'b101101, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("cnt_midload", 32'(match_cnt), 32'd0);
    send(32'b101101, 6, 32'b000001);
    idle(2);
    check("cnt_after_midload", 32'(match_cnt), 32'd1);

    // len=1 saturation, upper pattern bits must be masked off
    load(16'hFFF1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'b0111111, 7, 32'b0111111);
    check("cnt_saturated", 32'(match_cnt), 32'd3);
    exp_cnt = 2'd0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    idle(2);
    check("cnt_cleared", 32'(match_cnt), 32'd0);

    // Full 16-bit pattern
    load(16'hA5C3, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000A5C3, 16, 32'h1);
    idle(2);
    load(16'hA5C3, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000A5C3 ^ 32'h8000, 16, 32'h0);
    idle(2);
    check("cnt_flipped", 32'(match_cnt), 32'd0);

    // Async reset while b is high
    load(16'hA5C3, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000A5C3, 16, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("b_before_rst", 32'(b), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("b_async_rst", 32'(b), 32'd0);
    check("armed_async_rst", 32'(armed), 32'd0);
    check("cnt_async_rst", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 2'd0;
    send(32'h0000A5C3, 16, 32'h0);
    idle(2);
    check("armed_after_rst", 32'(armed), 32'd0);

    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
